// File: rtl/dmem_access_unit.sv
// Load/store unit between the processor data port and an async-read data memory.
// One request in flight; sub-word stores are done as read-modify-write of the word.
module dmem_access_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] wd_q, wd_d;

    function automatic logic req_is_bad(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = (size == 2'd3)
            || (size == 2'd1 && addr[0])
            || (size == 2'd2 && addr[1:0] != 2'b00)
            || ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] size, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    res = uns ? {24'd0, b} : 32'(b);
            2'd1:    res = uns ? {16'd0, h} : 32'(h);
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] lo, input logic [1:0] size);
        logic [31:0] res;
        res = word;
        if (size == 2'd0) begin
            res[{lo, 3'b000} +: 8] = wd[7:0];
        end else if (lo[1]) begin
            res[31:16] = wd[15:0];
        end else begin
            res[15:0] = wd[15:0];
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (req_is_bad(req_addr, req_size)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else begin
                        // wd_q holds the raw store data until MERGE folds it into the word
                        wd_d    = req_wdata;
                        state_d = (req_size == 2'd2) ? S_WRITE : S_MERGE;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_extend(mem_rd, addr_q[1:0], size_q, uns_q);
                state_d = S_RESP;
            end
            S_MERGE: begin
                wd_d    = merge_lane(mem_rd, wd_q, addr_q[1:0], size_q);
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    // Gated by reset so a reset landing on the WRITE cycle never commits the store
    assign mem_we    = (state_q == S_WRITE) && !reset;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wd    = wd_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural async-read data memory.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    int          we_cnt = 0;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wd;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, measures accept-to-rsp_valid latency, checks response, then drains it.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_we);
        int lat;
        int we0;
        we0 = we_cnt;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_wecnt"}, 32'(we_cnt - we0), 32'(exp_we));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int we0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'h8070F0A0;
        mem[2] = 32'h11223344;
        mem[4] = 32'hCAFEF00D;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        reset = 1'b0;
        step();

        // Loads: lane select and extension
        do_req("ldb_s",  1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 2, 1'b0, 32'hFFFFFFF0, 0);
        do_req("ldh_u",  1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 2, 1'b0, 32'h00008070, 0);
        do_req("ldh_s",  1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 2, 1'b0, 32'hFFFF8070, 0);
        do_req("ldb_u7", 1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 2, 1'b0, 32'h00000080, 0);
        do_req("ldh_s4", 1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 2, 1'b0, 32'hFFFFF0A0, 0);
        do_req("ldw",    1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 2, 1'b0, 32'h8070F0A0, 0);

        // Stores: read-modify-write and full word
        do_req("stb", 1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFFFFAB, 3, 1'b0, 32'h0, 1);
        chk("stb_mem", mem[2], 32'h1122AB44);
        do_req("sth", 1'b1, 2'd1, 1'b0, 32'hA, 32'h00005566, 3, 1'b0, 32'h0, 1);
        chk("sth_mem", mem[2], 32'h5566AB44);
        do_req("stw", 1'b1, 2'd2, 1'b0, 32'hC, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
        chk("stw_mem", mem[3], 32'hDEADBEEF);

        // Errors never touch memory
        do_req("err_stw_mis", 1'b1, 2'd2, 1'b0, 32'h6, 32'h12345678, 1, 1'b1, 32'h0, 0);
        chk("err_stw_mem", mem[1], 32'h8070F0A0);
        do_req("err_range", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("err_size3", 1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("err_half",  1'b1, 2'd1, 1'b0, 32'h3, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("ok_last",   1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 2, 1'b0, 32'h0, 0);

        // Backpressure: response held while rsp_ready is low, no new request taken
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h4;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h8;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h000000A0);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
        chk("bp_rel_ready", 32'(req_ready), 32'd1);
        do_req("bp_next", 1'b0, 2'd0, 1'b1, 32'h8, 32'h0, 2, 1'b0, 32'h00000044, 0);

        // Reset landing on the WRITE cycle of a word store
        we0 = we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10;
        req_wdata = 32'h12345678;
        step();
        req_valid = 1'b0;
        chk("rw_mem_we_pre", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_mem_we_rst", 32'(mem_we), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rw_mem", mem[4], 32'hCAFEF00D);
        chk("rw_wecnt", 32'(we_cnt - we0), 32'd0);
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_req_ready", 32'(req_ready), 32'd1);
        step();
        chk("rw_after_valid", 32'(rsp_valid), 32'd0);
        do_req("rw_next", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hCAFEF00D, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
